// File: rtl/gptp_pkg.sv
// Shared types and constants for the gPTP timestamp write path.
package gptp_pkg;

    localparam int unsigned GPTP_ADDR_W = 8;
    localparam int unsigned GPTP_TS_W   = 80;

    localparam logic SRC_RX = 1'b0;
    localparam logic SRC_TX = 1'b1;

    typedef struct packed {
        logic [GPTP_ADDR_W-1:0] addr;
        logic [GPTP_TS_W-1:0]   data1;
        logic [GPTP_TS_W-1:0]   data2;
    } wr_rec_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    // Saturating 16-bit increment used by the optional statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/gptp_rr_arb2.sv
// Two-requester round-robin grant; pointer names the preferred source on a tie.
module gptp_rr_arb2
    import gptp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_rx,
    input  logic req_tx,
    input  logic en,
    input  logic advance,
    output logic gnt_rx,
    output logic gnt_tx
);

    logic ptr_q, ptr_d;

    // Grant a lone requester directly; on a tie the pointer decides.
    always_comb begin
        gnt_rx = en & req_rx & (~req_tx | (ptr_q == SRC_RX));
        gnt_tx = en & req_tx & (~req_rx | (ptr_q == SRC_TX));
        ptr_d  = ptr_q;
        if (advance) begin
            ptr_d = gnt_rx ? SRC_TX : SRC_RX;
        end
    end

    // Pointer register, starts preferring rx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SRC_RX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gptp_rev_wr_arbiter.sv
// Round-robin arbiter of rx/tx timestamp writes into the shared store,
// with a one-entry output register and a drop watchdog.
// Optional statistics ports: define GPTP_WR_ARB_STATS_EN.
module gptp_rev_wr_arbiter
    import gptp_pkg::*;
#(
    parameter int unsigned ADDR_W         = GPTP_ADDR_W,
    parameter int unsigned TS_W           = GPTP_TS_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_CNT_W       = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_wr_vaild,
    output logic              rx_wr_ready,
    input  logic [ADDR_W-1:0] rx_wr_addr,
    input  logic [TS_W-1:0]   rx_wr_data1,
    input  logic [TS_W-1:0]   rx_wr_data2,
    input  logic              tx_wr_vaild,
    output logic              tx_wr_ready,
    input  logic [ADDR_W-1:0] tx_wr_addr,
    input  logic [TS_W-1:0]   tx_wr_data1,
    input  logic [TS_W-1:0]   tx_wr_data2,
    output logic              out_wr_vaild,
    input  logic              out_wr_ready,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [TS_W-1:0]   out_wr_data1,
    output logic [TS_W-1:0]   out_wr_data2,
    output logic              out_wr_src,
    output logic              err_timeout
`ifdef GPTP_WR_ARB_STATS_EN
    ,
    output logic [15:0]       rx_grant_cnt,
    output logic [15:0]       tx_grant_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    arb_state_t            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [TS_W-1:0]       data1_q, data1_d;
    logic [TS_W-1:0]       data2_q, data2_d;
    logic                  src_q, src_d;
    logic                  err_q, err_d;
    logic [TO_CNT_W-1:0]   wd_q, wd_d;
    logic                  can_load;
    logic                  gnt_rx, gnt_tx, grant;
    logic                  wd_expired;

    // Ready is masked while reset is held so nothing is accepted during reset.
    gptp_rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (reset),
        .req_rx  (rx_wr_vaild),
        .req_tx  (tx_wr_vaild),
        .en      (can_load & reset),
        .advance (grant),
        .gnt_rx  (gnt_rx),
        .gnt_tx  (gnt_tx)
    );

    // Load permission, grant and watchdog threshold decode.
    always_comb begin
        can_load   = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & out_wr_ready);
        grant      = gnt_rx | gnt_tx;
        wd_expired = (wd_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Next state: load on grant, drain on ready, otherwise count towards drop.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data1_d = data1_q;
        data2_d = data2_q;
        src_d   = src_q;
        err_d   = 1'b0;
        wd_d    = wd_q;
        if (grant) begin
            state_d = ST_FULL;
            addr_d  = gnt_tx ? tx_wr_addr  : rx_wr_addr;
            data1_d = gnt_tx ? tx_wr_data1 : rx_wr_data1;
            data2_d = gnt_tx ? tx_wr_data2 : rx_wr_data2;
            src_d   = gnt_tx ? SRC_TX : SRC_RX;
            wd_d    = '0;
        end else if (state_q == ST_FULL) begin
            // Ready is tested before the threshold so a last-moment accept wins.
            if (out_wr_ready) begin
                state_d = ST_EMPTY;
                wd_d    = '0;
            end else if (wd_expired) begin
                state_d = ST_EMPTY;
                err_d   = 1'b1;
                wd_d    = '0;
            end else begin
                wd_d    = wd_q + 1'b1;
            end
        end
    end

    // Output register, state and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            addr_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            src_q   <= SRC_RX;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            src_q   <= src_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // Port mapping.
    always_comb begin
        rx_wr_ready  = gnt_rx;
        tx_wr_ready  = gnt_tx;
        out_wr_vaild = (state_q == ST_FULL);
        out_wr_addr  = addr_q;
        out_wr_data1 = data1_q;
        out_wr_data2 = data2_q;
        out_wr_src   = src_q;
        err_timeout  = err_q;
    end

`ifdef GPTP_WR_ARB_STATS_EN
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating grant and drop counters.
    always_comb begin
        rx_cnt_d   = sat_inc16(rx_cnt_q, gnt_rx);
        tx_cnt_d   = sat_inc16(tx_cnt_q, gnt_tx);
        drop_cnt_d = sat_inc16(drop_cnt_q, err_d);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Statistics port mapping.
    always_comb begin
        rx_grant_cnt = rx_cnt_q;
        tx_grant_cnt = tx_cnt_q;
        drop_cnt     = drop_cnt_q;
    end
`else
    // Statistics counters not built.
`endif

endmodule
